// File: rtl/contador_transiciones_sinc_pkg.sv
// Shared definitions for the transition-count monitor: FSM encoding,
// default widths and the channel numbering of the adder bank.
package contador_transiciones_sinc_pkg;

  localparam int NUM_CANALES_DEF = 3;
  localparam int ANCHO_DEF       = 9;
  localparam int ANCHO_CNT_DEF   = 32;
  localparam int NDIR_DEF        = 2;

  localparam int CANAL_RIZADO = 0;
  localparam int CANAL_LOGICO = 1;
  localparam int CANAL_LOOK   = 2;

  typedef enum logic [0:0] {
    ACTIVO = 1'b0,
    LIMPIA = 1'b1
  } estado_t;

  // Width of an index able to address n entries (at least one bit).
  function automatic int ancho_indice(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/contador_transiciones_sinc_contador_unos.sv
// Combinational population count of an ANCHO-bit vector.
module contador_unos
  import contador_transiciones_sinc_pkg::*;
#(
  parameter int ANCHO     = ANCHO_DEF,
  parameter int ANCHO_OUT = $clog2(ANCHO + 1)
) (
  input  logic [ANCHO-1:0]     vec,
  output logic [ANCHO_OUT-1:0] cuenta
);

  // Add up every set bit of the input vector.
  always_comb begin
    cuenta = '0;
    for (int i = 0; i < ANCHO; i++) begin
      cuenta = cuenta + ANCHO_OUT'(vec[i]);
    end
  end

endmodule

// File: rtl/contador_transiciones_sinc.sv
// Transition-count monitor for the adder bank: accumulates the Hamming
// distance between consecutive samples of each bus into a saturating
// counter, serves counter reads over a request/valid handshake and
// clears all counters sequentially, one per cycle.
module contador_transiciones_sinc
  import contador_transiciones_sinc_pkg::*;
#(
  parameter int NUM_CANALES = NUM_CANALES_DEF,
  parameter int ANCHO       = ANCHO_DEF,
  parameter int ANCHO_CNT   = ANCHO_CNT_DEF,
  parameter int NDIR        = NDIR_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         muestra_en,
  input  logic [NUM_CANALES*ANCHO-1:0] bus_in,
  input  logic                         borrar,
  input  logic                         lee_req,
  input  logic [NDIR-1:0]              lee_dir,
  output logic                         dato_valido,
  output logic [ANCHO_CNT-1:0]         dato_out,
  output logic                         lee_err,
  output logic                         ocupado,
  output logic [NUM_CANALES-1:0]       saturado
);

  localparam int PW = $clog2(ANCHO + 1);
  localparam int IW = ancho_indice(NUM_CANALES);

  estado_t              estado_r, estado_sig_s;
  logic [IW-1:0]        idx_r, idx_sig_s;
  logic                 sale_s;
  logic                 primera_r;
  logic                 muestra_s;
  logic                 acepta_s;
  logic [ANCHO_CNT-1:0] rd_s;
  logic                 rd_err_s;

  logic [ANCHO-1:0]     prev_r [NUM_CANALES];
  logic [ANCHO_CNT-1:0] cnt_r  [NUM_CANALES];
  logic [PW-1:0]        pc_s   [NUM_CANALES];
  logic [ANCHO_CNT:0]   suma_s [NUM_CANALES];

  // One popcount per channel over the bits that toggled since the last sample.
  for (genvar k = 0; k < NUM_CANALES; k++) begin : g_canal
    contador_unos #(.ANCHO(ANCHO), .ANCHO_OUT(PW)) u_unos (
      .vec    (prev_r[k] ^ bus_in[k*ANCHO +: ANCHO]),
      .cuenta (pc_s[k])
    );
  end

  // Sampling is suppressed while clearing and when a clear is requested.
  always_comb begin
    muestra_s = (estado_r == ACTIVO) && muestra_en && !borrar;
    acepta_s  = lee_req && (estado_r == ACTIVO) && !borrar && !dato_valido;
  end

  // Extended-width sums; the top bit flags an overflow of the counter range.
  always_comb begin
    for (int k = 0; k < NUM_CANALES; k++) begin
      suma_s[k] = {1'b0, cnt_r[k]} + (ANCHO_CNT + 1)'(pc_s[k]);
    end
  end

  // Read multiplexer; an address beyond the last channel reads as an error.
  always_comb begin
    rd_s     = '0;
    rd_err_s = 1'b1;
    for (int k = 0; k < NUM_CANALES; k++) begin
      if (lee_dir == NDIR'(k)) begin
        rd_s     = cnt_r[k];
        rd_err_s = 1'b0;
      end else begin
        rd_s     = rd_s;
        rd_err_s = rd_err_s;
      end
    end
  end

  // Next-state logic: a clear walks the index once over every channel.
  always_comb begin
    estado_sig_s = estado_r;
    idx_sig_s    = idx_r;
    sale_s       = 1'b0;
    case (estado_r)
      ACTIVO: begin
        if (borrar) begin
          estado_sig_s = LIMPIA;
          idx_sig_s    = '0;
        end else begin
          estado_sig_s = ACTIVO;
        end
      end
      LIMPIA: begin
        if (borrar) begin
          idx_sig_s = '0;
        end else if (idx_r == IW'(NUM_CANALES - 1)) begin
          estado_sig_s = ACTIVO;
          sale_s       = 1'b1;
        end else begin
          idx_sig_s = idx_r + IW'(1);
        end
      end
      default: begin
        estado_sig_s = ACTIVO;
        idx_sig_s    = '0;
      end
    endcase
  end

  // FSM state, clear index and the busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_r <= ACTIVO;
      idx_r    <= '0;
      ocupado  <= 1'b0;
    end else begin
      estado_r <= estado_sig_s;
      idx_r    <= idx_sig_s;
      ocupado  <= (estado_sig_s == LIMPIA);
    end
  end

  // Sample history, saturating counters, sticky flags and the first-sample marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primera_r <= 1'b1;
      saturado  <= '0;
      for (int k = 0; k < NUM_CANALES; k++) begin
        prev_r[k] <= '0;
        cnt_r[k]  <= '0;
      end
    end else begin
      if (sale_s) begin
        primera_r <= 1'b1;
      end else if (muestra_s) begin
        primera_r <= 1'b0;
      end
      for (int k = 0; k < NUM_CANALES; k++) begin
        if ((estado_r == LIMPIA) && (idx_r == IW'(k))) begin
          cnt_r[k]    <= '0;
          saturado[k] <= 1'b0;
        end else if (muestra_s) begin
          prev_r[k] <= bus_in[k*ANCHO +: ANCHO];
          if (!primera_r) begin
            if (suma_s[k][ANCHO_CNT]) begin
              cnt_r[k]    <= '1;
              saturado[k] <= 1'b1;
            end else begin
              cnt_r[k] <= suma_s[k][ANCHO_CNT-1:0];
            end
          end
        end
      end
    end
  end

  // Read response: one-cycle valid pulse, data held between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dato_valido <= 1'b0;
      dato_out    <= '0;
      lee_err     <= 1'b0;
    end else begin
      dato_valido <= acepta_s;
      if (acepta_s) begin
        dato_out <= rd_s;
        lee_err  <= rd_err_s;
      end
    end
  end

endmodule

// File: tb/tb_contador_transiciones_sinc.sv
// Self-checking bench: two instances (32-bit and 4-bit counters) share the
// same stimulus and are compared every cycle against a behavioural model,
// plus table vectors and hand-written corner-case sequences.
module tb_contador_transiciones_sinc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        muestra_en;
  logic [26:0] bus_in;
  logic        borrar;
  logic        lee_req;
  logic [1:0]  lee_dir;

  logic        dv0, dv1, err0, err1, ocu0, ocu1;
  logic [31:0] dout0;
  logic [3:0]  dout1;
  logic [2:0]  sat0, sat1;

  always #5 clk = ~clk;

  contador_transiciones_sinc #(.NUM_CANALES(3), .ANCHO(9), .ANCHO_CNT(32), .NDIR(2)) dut (
    .clk(clk), .rst_n(rst_n), .muestra_en(muestra_en), .bus_in(bus_in),
    .borrar(borrar), .lee_req(lee_req), .lee_dir(lee_dir),
    .dato_valido(dv0), .dato_out(dout0), .lee_err(err0),
    .ocupado(ocu0), .saturado(sat0)
  );

  contador_transiciones_sinc #(.NUM_CANALES(3), .ANCHO(9), .ANCHO_CNT(4), .NDIR(2)) dut_chico (
    .clk(clk), .rst_n(rst_n), .muestra_en(muestra_en), .bus_in(bus_in),
    .borrar(borrar), .lee_req(lee_req), .lee_dir(lee_dir),
    .dato_valido(dv1), .dato_out(dout1), .lee_err(err1),
    .ocupado(ocu1), .saturado(sat1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model; index [d] selects the instance (0: 32-bit, 1: 4-bit).
  longint     m_cnt [2][3];
  logic [8:0] m_prev [3];
  bit         m_primera;
  bit [2:0]   m_sat [2];
  int         m_left, m_pos;
  bit         m_valid, m_err;
  longint     m_out [2];
  longint     m_max [2];

  function void m_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 3; k++) m_cnt[d][k] = 0;
      m_sat[d] = 3'b000;
      m_out[d] = 0;
    end
    for (int k = 0; k < 3; k++) m_prev[k] = 9'h000;
    m_max[0]  = 64'hFFFF_FFFF;
    m_max[1]  = 15;
    m_primera = 1'b1;
    m_left    = 0;
    m_pos     = 0;
    m_valid   = 1'b0;
    m_err     = 1'b0;
  endfunction

  function void m_step();
    bit         active, acc;
    logic [8:0] nb;
    longint     s;
    active = (m_left == 0);
    acc    = lee_req && active && !borrar && !m_valid;
    m_valid = acc;
    if (acc) begin
      m_err = (lee_dir >= 2'd3);
      for (int d = 0; d < 2; d++) begin
        if (m_err) m_out[d] = 0;
        else       m_out[d] = m_cnt[d][lee_dir];
      end
    end
    if (active) begin
      if (borrar) begin
        m_left = 3;
        m_pos  = 0;
      end else if (muestra_en) begin
        for (int k = 0; k < 3; k++) begin
          nb = bus_in[k*9 +: 9];
          if (!m_primera) begin
            for (int d = 0; d < 2; d++) begin
              s = m_cnt[d][k] + $countones(m_prev[k] ^ nb);
              if (s > m_max[d]) begin
                s = m_max[d];
                m_sat[d][k] = 1'b1;
              end
              m_cnt[d][k] = s;
            end
          end
          m_prev[k] = nb;
        end
        m_primera = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_cnt[d][m_pos] = 0;
        m_sat[d][m_pos] = 1'b0;
      end
      if (borrar) begin
        m_left = 3;
        m_pos  = 0;
      end else begin
        m_pos++;
        m_left--;
        if (m_left == 0) m_primera = 1'b1;
      end
    end
  endfunction

  // One clock: advance the model, then compare both instances.
  task automatic step();
    m_step();
    @(posedge clk);
    #1;
    chk("valido", dv0, m_valid);
    chk("valido_chico", dv1, m_valid);
    chk("ocupado", ocu0, m_left != 0);
    chk("ocupado_chico", ocu1, m_left != 0);
    chk("saturado", sat0, m_sat[0]);
    chk("saturado_chico", sat1, m_sat[1]);
    if (m_valid) begin
      chk("dato", dout0, m_out[0]);
      chk("dato_chico", dout1, m_out[1]);
      chk("lee_err", err0, m_err);
      chk("lee_err_chico", err1, m_err);
    end
  endtask

  function automatic logic [26:0] pk(input logic [8:0] c0, input logic [8:0] c1, input logic [8:0] c2);
    return {c2, c1, c0};
  endfunction

  task automatic idle();
    muestra_en = 1'b0;
    borrar     = 1'b0;
    lee_req    = 1'b0;
    step();
  endtask

  task automatic leer(input logic [1:0] dir, input longint e0, input longint e1, input string name);
    lee_req = 1'b1;
    lee_dir = dir;
    step();
    lee_req = 1'b0;
    chk({name, "_valido"}, dv0, 1'b1);
    chk({name, "_dato"}, dout0, e0);
    chk({name, "_dato_chico"}, dout1, e1);
    step();
  endtask

  typedef struct {
    bit          m;
    logic [26:0] bus;
    bit          rq;
    logic [1:0]  dir;
    bit          ev;
    logic [31:0] eo;
  } vec_t;

  vec_t tbl[$];

  initial begin
    longint e0[3], e1[3];
    bit     es[3];
    int     ocu_cnt, npul;
    bit     got;

    rst_n = 1'b0; muestra_en = 1'b0; bus_in = '0; borrar = 1'b0;
    lee_req = 1'b0; lee_dir = 2'd0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valido", dv0, 1'b0);
    chk("rst_dato", dout0, 32'd0);
    chk("rst_err", err0, 1'b0);
    chk("rst_ocupado", ocu0, 1'b0);
    chk("rst_saturado", sat0, 3'b000);
    rst_n = 1'b1;

    // Single toggle on ch0, then alternating ch2.
    tbl.push_back('{1'b1, pk(9'h000, 9'h000, 9'h0AA), 1'b0, 2'd0, 1'b0, 32'd0});
    tbl.push_back('{1'b1, pk(9'h1FF, 9'h000, 9'h0AA), 1'b0, 2'd0, 1'b0, 32'd0});
    tbl.push_back('{1'b0, pk(9'h1FF, 9'h000, 9'h0AA), 1'b1, 2'd0, 1'b1, 32'd9});
    tbl.push_back('{1'b0, pk(9'h1FF, 9'h000, 9'h0AA), 1'b0, 2'd0, 1'b0, 32'd0});
    tbl.push_back('{1'b0, pk(9'h1FF, 9'h000, 9'h0AA), 1'b1, 2'd1, 1'b1, 32'd0});
    tbl.push_back('{1'b0, pk(9'h1FF, 9'h000, 9'h0AA), 1'b0, 2'd0, 1'b0, 32'd0});
    tbl.push_back('{1'b0, pk(9'h1FF, 9'h000, 9'h0AA), 1'b1, 2'd2, 1'b1, 32'd0});
    tbl.push_back('{1'b0, pk(9'h1FF, 9'h000, 9'h0AA), 1'b0, 2'd0, 1'b0, 32'd0});
    tbl.push_back('{1'b1, pk(9'h1FF, 9'h000, 9'h0AA), 1'b0, 2'd0, 1'b0, 32'd0});
    tbl.push_back('{1'b1, pk(9'h1FF, 9'h000, 9'h055), 1'b0, 2'd0, 1'b0, 32'd0});
    tbl.push_back('{1'b1, pk(9'h1FF, 9'h000, 9'h0AA), 1'b0, 2'd0, 1'b0, 32'd0});
    tbl.push_back('{1'b1, pk(9'h1FF, 9'h000, 9'h055), 1'b0, 2'd0, 1'b0, 32'd0});
    tbl.push_back('{1'b1, pk(9'h1FF, 9'h000, 9'h0AA), 1'b0, 2'd0, 1'b0, 32'd0});
    tbl.push_back('{1'b0, pk(9'h1FF, 9'h000, 9'h0AA), 1'b1, 2'd2, 1'b1, 32'd32});
    tbl.push_back('{1'b0, pk(9'h1FF, 9'h000, 9'h0AA), 1'b0, 2'd0, 1'b0, 32'd0});
    tbl.push_back('{1'b0, pk(9'h1FF, 9'h000, 9'h0AA), 1'b1, 2'd0, 1'b1, 32'd9});
    tbl.push_back('{1'b0, pk(9'h1FF, 9'h000, 9'h0AA), 1'b0, 2'd0, 1'b0, 32'd0});

    foreach (tbl[i]) begin
      muestra_en = tbl[i].m;
      bus_in     = tbl[i].bus;
      borrar     = 1'b0;
      lee_req    = tbl[i].rq;
      lee_dir    = tbl[i].dir;
      step();
      chk("tbl_valido", dv0, tbl[i].ev);
      if (tbl[i].ev) chk("tbl_dato", dout0, tbl[i].eo);
    end
    lee_req = 1'b0;
    chk("t2_sin_saturar", sat0, 3'b000);

    // Saturation of the 4-bit counter on ch1.
    e0 = '{9, 18, 27};
    e1 = '{9, 15, 15};
    es = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      muestra_en = 1'b1;
      bus_in = pk(9'h1FF, (i % 2 == 0) ? 9'h1FF : 9'h000, 9'h0AA);
      step();
      muestra_en = 1'b0;
      leer(2'd1, e0[i], e1[i], "t3");
      chk("t3_saturado1", sat1[1], es[i]);
    end

    // Sequenced clear with a read pending across it.
    borrar = 1'b1;
    step();
    chk("t4_ocupado_inicio", ocu0, 1'b1);
    chk("t4_saturado_chico", sat1[1], 1'b1);
    borrar  = 1'b0;
    lee_req = 1'b1;
    lee_dir = 2'd1;
    ocu_cnt = 1;
    got     = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      step();
      if (dv0) begin
        got = 1'b1;
        chk("t4_ocupado_en_valido", ocu0, 1'b0);
        chk("t4_dato", dout0, 32'd0);
      end else if (ocu0) begin
        ocu_cnt++;
      end
    end
    lee_req = 1'b0;
    chk("t4_lectura_atendida", got, 1'b1);
    chk("t4_ciclos_ocupado", ocu_cnt, 3);
    chk("t4_saturado_borrado", sat1, 3'b000);
    muestra_en = 1'b1;
    bus_in = pk(9'h000, 9'h1FF, 9'h055);
    step();
    muestra_en = 1'b0;
    leer(2'd1, 0, 0, "t4_primera");
    muestra_en = 1'b1;
    bus_in = pk(9'h000, 9'h000, 9'h055);
    step();
    muestra_en = 1'b0;
    leer(2'd1, 9, 9, "t4_cuenta");

    // Out-of-range address and held request.
    lee_req = 1'b1;
    lee_dir = 2'd3;
    step();
    chk("t5_valido", dv0, 1'b1);
    chk("t5_dato", dout0, 32'd0);
    chk("t5_err", err0, 1'b1);
    step();
    lee_req = 1'b0;
    step();
    lee_req = 1'b1;
    lee_dir = 2'd0;
    npul = 0;
    repeat (4) begin
      step();
      if (dv0) npul++;
    end
    lee_req = 1'b0;
    chk("t5_pulsos", npul, 2);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      muestra_en = 1'($urandom_range(0, 1));
      bus_in     = 27'($urandom);
      borrar     = ($urandom_range(0, 15) == 0);
      lee_req    = 1'($urandom_range(0, 1));
      lee_dir    = 2'($urandom_range(0, 3));
      step();
    end

    // Reset in the middle of a clear.
    repeat (5) idle();
    for (int i = 0; i < 3; i++) begin
      muestra_en = 1'b1;
      bus_in = (i % 2 == 0) ? pk(9'h000, 9'h000, 9'h000) : pk(9'h1FF, 9'h1FF, 9'h1FF);
      step();
    end
    muestra_en = 1'b0;
    borrar = 1'b1;
    step();
    borrar = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("t6_valido", dv0, 1'b0);
    chk("t6_dato", dout0, 32'd0);
    chk("t6_err", err0, 1'b0);
    chk("t6_ocupado", ocu0, 1'b0);
    chk("t6_saturado", sat0, 3'b000);
    chk("t6_ocupado_chico", ocu1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    leer(2'd0, 0, 0, "t6_canal0");
    leer(2'd1, 0, 0, "t6_canal1");
    leer(2'd2, 0, 0, "t6_canal2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
